pio_tx_osr: RTL and testbench

TX FIFO plus output shift register (OSR) for one PIO state machine. Sits directly upstream of the state machine decode stage. System-side writes are buffered in a FIFO. The state machine drains the FIFO through PULL (explicit or autopull) and consumes OSR bits through OUT. The block exports OSR-empty status for the state machine's `!OSRE` jump condition.

---
 rtl/pio_tx_osr_if.sv | 41 ++++
 rtl/pio_tx_osr.sv | 119 +++++++++++
 tb/tb_pio_tx_osr.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_tx_osr_if.sv
// pio_tx_osr_if: system write port and state-machine PULL/OUT port of the
// PIO TX FIFO + output shift register. The master drives requests; the slave
// (pio_tx_osr) returns status, stall flags and shifted data.
interface pio_tx_osr_if #(
  parameter int DATA_W = 32
) ();
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              fifo_full;
  logic [3:0]        fifo_level;
  logic              txover;
  logic              txover_clr;
  logic              pull_req;
  logic              pull_block;
  logic              pull_ifempty;
  logic [DATA_W-1:0] pull_x;
  logic              pull_stall;
  logic              out_req;
  logic [5:0]        out_bits;
  logic [DATA_W-1:0] out_data;
  logic              out_stall;
  logic              shift_right;
  logic              autopull_en;
  logic [4:0]        pull_thresh;
  logic [5:0]        osr_count;
  logic              osre;

  modport master (
    output wr_en, wr_data, txover_clr, pull_req, pull_block, pull_ifempty,
           pull_x, out_req, out_bits, shift_right, autopull_en, pull_thresh,
    input  fifo_full, fifo_level, txover, pull_stall, out_data, out_stall,
           osr_count, osre
  );

  modport slave (
    input  wr_en, wr_data, txover_clr, pull_req, pull_block, pull_ifempty,
           pull_x, out_req, out_bits, shift_right, autopull_en, pull_thresh,
    output fifo_full, fifo_level, txover, pull_stall, out_data, out_stall,
           osr_count, osre
  );
endinterface

// File: rtl/pio_tx_osr.sv
// pio_tx_osr: TX FIFO feeding the output shift register of one PIO state
// machine. Handles explicit PULL, autopull refill and OUT shifting.
// Build option: define PIO_TX_FIFO_JOIN_EN to double FIFO capacity to 2*DEPTH.
// A write that coincides with a pop is accepted even when the FIFO is full.
module pio_tx_osr #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  pio_tx_osr_if.slave bus
);
`ifdef PIO_TX_FIFO_JOIN_EN
  localparam int CAP = 2 * DEPTH;
`else
  localparam int CAP = DEPTH;
`endif
  localparam int PTR_W = $clog2(CAP);

  logic [DATA_W-1:0] r_mem [CAP];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [3:0]        r_level;
  logic              r_txover;
  logic [DATA_W-1:0] r_osr;
  logic [5:0]        r_count;

  logic [5:0]        w_thresh;
  logic [5:0]        w_n;
  logic [5:0]        w_n_inv;
  logic [6:0]        w_sum;
  logic              w_osre;
  logic              w_empty;
  logic              w_full;
  logic              w_pull_live;
  logic              w_pull_pop;
  logic              w_pull_x;
  logic              w_auto;
  logic              w_out_go;
  logic              w_pop;
  logic              w_push;
  logic              w_load;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_out_shift;
  logic [DATA_W-1:0] w_osr_shift;

  // Decode PULL/OUT/autopull decisions and the shifter result for this cycle.
  always_comb begin
    w_thresh    = (bus.pull_thresh == 5'd0) ? 6'd32 : {1'b0, bus.pull_thresh};
    w_n         = (bus.out_bits == 6'd0) ? 6'd32 : bus.out_bits;
    w_n_inv     = 6'd32 - w_n;
    w_sum       = {1'b0, r_count} + {1'b0, w_n};
    w_osre      = (r_count >= w_thresh);
    w_empty     = (r_level == 4'd0);
    w_full      = (r_level == 4'(CAP));
    // A conditional PULL below threshold is a plain no-op.
    w_pull_live = bus.pull_req && !(bus.pull_ifempty && !w_osre);
    w_pull_pop  = w_pull_live && !w_empty;
    w_pull_x    = w_pull_live && w_empty && !bus.pull_block;
    // A stalled OUT counts as idle, so the refill lands in the stall cycle.
    w_auto      = bus.autopull_en && w_osre && !w_empty && !bus.pull_req;
    w_out_go    = bus.out_req && !bus.pull_req && !(bus.autopull_en && w_osre);
    w_pop       = w_pull_pop || w_auto;
    w_push      = bus.wr_en && (!w_full || w_pop);
    w_load      = w_pop || w_pull_x;
    w_load_val  = w_pop ? r_mem[r_rd_ptr] : bus.pull_x;
    if (bus.shift_right) begin
      w_out_shift = (r_osr << w_n_inv) >> w_n_inv;
      w_osr_shift = r_osr >> w_n;
    end else begin
      w_out_shift = r_osr >> w_n_inv;
      w_osr_shift = r_osr << w_n;
    end
  end

  assign bus.out_data   = w_out_go ? w_out_shift : '0;
  assign bus.out_stall  = bus.out_req && !w_out_go;
  assign bus.pull_stall = w_pull_live && w_empty && bus.pull_block;
  assign bus.fifo_full  = w_full;
  assign bus.fifo_level = r_level;
  assign bus.txover     = r_txover;
  assign bus.osr_count  = r_count;
  assign bus.osre       = w_osre;

  // FIFO storage; not reset since only entries below the level are read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  // FIFO pointers, level and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 4'd0;
      r_txover <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + 4'd1;
      else if (w_pop && !w_push) r_level <= r_level - 4'd1;
      r_txover <= (r_txover && !bus.txover_clr) || (bus.wr_en && !w_push);
    end
  end

  // OSR: loads (PULL/refill) and shifts are mutually exclusive by construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_osr   <= '0;
      r_count <= 6'd32;
    end else if (w_load) begin
      r_osr   <= w_load_val;
      r_count <= 6'd0;
    end else if (w_out_go) begin
      r_osr   <= w_osr_shift;
      r_count <= (w_sum > 7'd32) ? 6'd32 : w_sum[5:0];
    end
  end
endmodule

// File: tb/tb_pio_tx_osr.sv
// tb_pio_tx_osr: directed steps then random traffic, every cycle compared
// against a queue-based reference model of the FIFO and OSR.
module tb_pio_tx_osr;
`ifdef PIO_TX_FIFO_JOIN_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 4;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails = 0;

  pio_tx_osr_if #(.DATA_W(32)) bus ();
  pio_tx_osr #(.DEPTH(4), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] q[$];
  logic [31:0] m_osr;
  int          m_cnt;
  bit          m_txover;
  logic [31:0] e_out_data;
  bit          e_out_stall;
  bit          e_pull_stall;
  // DUT combinational outputs sampled in the most recent step
  logic [31:0] s_out_data;
  logic        s_out_stall;
  logic        s_pull_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_osr = 32'd0;
    m_cnt = 32;
    m_txover = 1'b0;
  endtask

  task automatic idle();
    bus.wr_en = 0; bus.wr_data = 0; bus.txover_clr = 0;
    bus.pull_req = 0; bus.pull_block = 0; bus.pull_ifempty = 0; bus.pull_x = 0;
    bus.out_req = 0; bus.out_bits = 0; bus.shift_right = 1;
    bus.autopull_en = 0; bus.pull_thresh = 0;
  endtask

  // One clock of the behavioural model: expected outputs plus next state.
  task automatic model_step();
    int     thr, n;
    bit     osre, have, ovf;
    longint v;
    thr  = (bus.pull_thresh == 0) ? 32 : int'(bus.pull_thresh);
    n    = (bus.out_bits == 0) ? 32 : int'(bus.out_bits);
    osre = (m_cnt >= thr);
    have = (q.size() > 0);
    ovf  = 0;
    v    = longint'(m_osr);
    e_out_data = 32'd0; e_out_stall = 0; e_pull_stall = 0;
    if (bus.pull_req) begin
      if (bus.pull_ifempty && !osre) begin
        e_pull_stall = 0;
      end else if (have) begin
        m_osr = q.pop_front(); m_cnt = 0;
      end else if (bus.pull_block) begin
        e_pull_stall = 1;
      end else begin
        m_osr = bus.pull_x; m_cnt = 0;
      end
    end
    if (bus.out_req) begin
      if (bus.pull_req || (bus.autopull_en && osre)) begin
        e_out_stall = 1;
      end else begin
        if (bus.shift_right) begin
          e_out_data = 32'(v & ((longint'(1) << n) - 1));
          m_osr = 32'(v >> n);
        end else begin
          e_out_data = 32'(v >> (32 - n));
          m_osr = 32'(v << n);
        end
        m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
      end
    end
    if (!bus.pull_req && bus.autopull_en && osre && have) begin
      m_osr = q.pop_front(); m_cnt = 0;
    end
    if (bus.wr_en) begin
      if (q.size() < CAP) q.push_back(bus.wr_data);
      else ovf = 1;
    end
    m_txover = (m_txover && !bus.txover_clr) || ovf;
  endtask

  task automatic step();
    int lvl, cnt_pre, thr;
    bit txo;
    lvl = q.size(); txo = m_txover; cnt_pre = m_cnt;
    thr = (bus.pull_thresh == 0) ? 32 : int'(bus.pull_thresh);
    model_step();
    @(negedge clk);
    s_out_data = bus.out_data; s_out_stall = bus.out_stall; s_pull_stall = bus.pull_stall;
    chk("out_data",   s_out_data, e_out_data);
    chk("out_stall",  32'(s_out_stall), 32'(e_out_stall));
    chk("pull_stall", 32'(s_pull_stall), 32'(e_pull_stall));
    chk("fifo_level", 32'(bus.fifo_level), 32'(lvl));
    chk("fifo_full",  32'(bus.fifo_full), 32'(lvl == CAP));
    chk("txover",     32'(bus.txover), 32'(txo));
    chk("osr_count",  32'(bus.osr_count), 32'(cnt_pre));
    chk("osre",       32'(bus.osre), 32'(cnt_pre >= thr));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    idle();
    model_reset();
    #12 reset = 0;
    chk("rst_osr_count", 32'(bus.osr_count), 32'd32);
    chk("rst_osre", 32'(bus.osre), 32'd1);
    chk("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_fifo_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_txover", 32'(bus.txover), 32'd0);
    @(posedge clk); #1;

    // fill, overflow, clear
    for (int i = 1; i <= CAP; i++) begin
      bus.wr_en = 1; bus.wr_data = 32'hA5A5_0000 + 32'(i);
      step();
    end
    chk("fill_full", 32'(bus.fifo_full), 32'd1);
    chk("fill_level", 32'(bus.fifo_level), 32'(CAP));
    bus.wr_data = 32'hDEAD_BEEF;
    step();
    bus.wr_en = 0;
    chk("ovf_txover", 32'(bus.txover), 32'd1);
    chk("ovf_level", 32'(bus.fifo_level), 32'(CAP));
    bus.txover_clr = 1;
    step();
    bus.txover_clr = 0;
    chk("txover_clr", 32'(bus.txover), 32'd0);

    // drain with blocking PULLs; the last word must be the last one written
    bus.pull_req = 1; bus.pull_block = 1;
    repeat (CAP) step();
    bus.pull_req = 0;
    bus.out_req = 1; bus.out_bits = 0; bus.shift_right = 1;
    step();
    bus.out_req = 0;
    chk("drain_last", s_out_data, 32'hA5A5_0000 + 32'(CAP));

    // blocking PULL on empty, then a write lets it complete
    bus.pull_req = 1; bus.pull_block = 1;
    step();
    chk("pull_stall_empty", 32'(s_pull_stall), 32'd1);
    bus.wr_en = 1; bus.wr_data = 32'h1234_5678;
    step();
    bus.wr_en = 0;
    step();
    bus.pull_req = 0;
    chk("pull_done_stall", 32'(s_pull_stall), 32'd0);
    chk("pull_osr_count", 32'(bus.osr_count), 32'd0);

    // right shifts
    bus.out_req = 1; bus.out_bits = 6'd8; bus.shift_right = 1;
    step();
    chk("out8_data", s_out_data, 32'h0000_0078);
    chk("out8_count", 32'(bus.osr_count), 32'd8);
    bus.out_bits = 6'd0;
    step();
    bus.out_req = 0;
    chk("out32_data", s_out_data, 32'h0012_3456);
    chk("out32_count", 32'(bus.osr_count), 32'd32);

    // left shift
    bus.wr_en = 1; bus.wr_data = 32'hF000_0001;
    step();
    bus.wr_en = 0; bus.pull_req = 1; bus.pull_block = 1;
    step();
    bus.pull_req = 0; bus.shift_right = 0; bus.out_req = 1; bus.out_bits = 6'd4;
    step();
    bus.out_req = 0;
    chk("left4_data", s_out_data, 32'h0000_000F);

    // non-blocking PULL on empty loads pull_x
    bus.pull_req = 1; bus.pull_block = 0; bus.pull_x = 32'h55;
    step();
    bus.pull_req = 0; bus.shift_right = 1; bus.out_req = 1; bus.out_bits = 6'd0;
    step();
    bus.out_req = 0;
    chk("pull_x_data", s_out_data, 32'h0000_0055);

    // autopull with threshold 8
    bus.autopull_en = 1; bus.pull_thresh = 5'd8;
    bus.pull_req = 1; bus.pull_block = 0; bus.pull_x = 32'h1122_3344;
    step();
    bus.pull_req = 0; bus.wr_en = 1; bus.wr_data = 32'h0000_00AB;
    step();
    bus.wr_en = 0; bus.out_req = 1; bus.out_bits = 6'd8; bus.shift_right = 1;
    step();
    chk("ap_first_data", s_out_data, 32'h0000_0044);
    chk("ap_osre", 32'(bus.osre), 32'd1);
    step();
    chk("ap_stall", 32'(s_out_stall), 32'd1);
    step();
    chk("ap_refill_stall", 32'(s_out_stall), 32'd0);
    chk("ap_refill_data", s_out_data, 32'h0000_00AB);
    bus.out_req = 0; bus.autopull_en = 0; bus.pull_thresh = 0;

    // fill, overflow, then asynchronous reset mid-stream
    for (int i = 0; i < CAP; i++) begin
      bus.wr_en = 1; bus.wr_data = $urandom();
      step();
    end
    chk("fill2_full", 32'(bus.fifo_full), 32'd1);
    chk("fill2_level", 32'(bus.fifo_level), 32'(CAP));
    step();
    bus.pull_req = 1; bus.pull_block = 1;
    step();
    #3 reset = 1;
    #1;
    chk("mid_rst_level", 32'(bus.fifo_level), 32'd0);
    chk("mid_rst_count", 32'(bus.osr_count), 32'd32);
    chk("mid_rst_osre", 32'(bus.osre), 32'd1);
    chk("mid_rst_full", 32'(bus.fifo_full), 32'd0);
    chk("mid_rst_txover", 32'(bus.txover), 32'd0);
    idle();
    model_reset();
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      bus.wr_en        = ($urandom_range(0, 99) < 45);
      bus.wr_data      = $urandom();
      bus.txover_clr   = ($urandom_range(0, 19) == 0);
      bus.pull_req     = (r < 20) || (r >= 97);
      bus.out_req      = ((r >= 20) && (r < 65)) || (r >= 97);
      bus.pull_block   = 1'($urandom_range(0, 1));
      bus.pull_ifempty = ($urandom_range(0, 3) == 0);
      bus.pull_x       = $urandom();
      bus.out_bits     = 6'($urandom_range(0, 32));
      bus.shift_right  = 1'($urandom_range(0, 1));
      bus.autopull_en  = 1'($urandom_range(0, 1));
      bus.pull_thresh  = 5'($urandom_range(0, 31));
      step();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
